// File: rtl/apb_dma_regfile_pkg.sv
// Shared register indices, hw_upd_data slice offsets and APB FSM encoding
// for the multi-channel DMA register file.
package apb_dma_regfile_pkg;

  localparam int REG_CMD          = 0;
  localparam int REG_STATUS       = 1;
  localparam int REG_INTREN       = 2;
  localparam int REG_CTRL         = 3;
  localparam int REG_SRCADDR      = 4;
  localparam int REG_DESADDR      = 5;
  localparam int REG_XSIZE        = 6;
  localparam int REG_SRCTRANSCFG  = 7;
  localparam int REG_DESTRANSCFG  = 8;
  localparam int REG_XADDRINC     = 9;
  localparam int REG_FILLVAL      = 10;
  localparam int REG_SRCTRIGINCFG = 11;
  localparam int REG_DESTRIGINCFG = 12;
  localparam int REG_TRIGOUTCFG   = 13;
  localparam int REG_LINKADDR     = 14;
  localparam int REG_WRKREGPTR    = 15;
  localparam int REG_WRKREGVAL    = 16;
  localparam int NUM_REGS_RW      = 16;

  // hw_upd_data is packed as {XSIZE, DESADDR, SRCADDR}
  localparam int HW_SRCADDR_LSB = 0;
  localparam int HW_DESADDR_LSB = 32;
  localparam int HW_XSIZE_LSB   = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    for (int i = 0; i < 4; i++) begin
      strb_mask[i*8 +: 8] = {8{strb[i]}};
    end
  endfunction

endpackage

// File: rtl/apb_dma_ch_regs.sv
// One channel page: 16 writable registers with byte-strobe merge, W1C STATUS,
// ENABLECMD clear and hardware update of SRCADDR/DESADDR/XSIZE.
module apb_dma_ch_regs
  import apb_dma_regfile_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [3:0]                   wr_idx,
  input  logic [31:0]                  wr_data,
  input  logic [3:0]                   wr_strb,
  input  logic [31:0]                  sts_set,
  input  logic                         cmd_clr,
  input  logic                         hw_upd_en,
  input  logic [95:0]                  hw_upd_data,
  output logic [NUM_REGS_RW*32-1:0]    regs
);

  logic [31:0] regs_q [NUM_REGS_RW];
  logic [31:0] regs_d [NUM_REGS_RW];
  logic [31:0] mask;
  logic [31:0] sts_clr;

  always_comb begin
    mask    = strb_mask(wr_strb);
    sts_clr = '0;
    for (int r = 0; r < NUM_REGS_RW; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_en && (32'(wr_idx) == r)) begin
        regs_d[r] = (regs_q[r] & ~mask) | (wr_data & mask);
      end
    end

    // STATUS is write-one-to-clear; a same-cycle hardware set wins
    if (wr_en && (32'(wr_idx) == REG_STATUS)) begin
      sts_clr = wr_data & mask;
    end
    regs_d[REG_STATUS] = (regs_q[REG_STATUS] & ~sts_clr) | sts_set;

    if (cmd_clr) begin
      regs_d[REG_CMD][0] = 1'b0;
    end

    // The APB write keeps the register it addresses; hw loads the rest
    if (hw_upd_en) begin
      if (!(wr_en && (32'(wr_idx) == REG_SRCADDR))) begin
        regs_d[REG_SRCADDR] = hw_upd_data[HW_SRCADDR_LSB +: 32];
      end
      if (!(wr_en && (32'(wr_idx) == REG_DESADDR))) begin
        regs_d[REG_DESADDR] = hw_upd_data[HW_DESADDR_LSB +: 32];
      end
      if (!(wr_en && (32'(wr_idx) == REG_XSIZE))) begin
        regs_d[REG_XSIZE] = hw_upd_data[HW_XSIZE_LSB +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS_RW; r++) begin
      if (reset) begin
        regs_q[r] <= '0;
      end else begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS_RW; gi++) begin : g_flat
      assign regs[gi*32 +: 32] = regs_q[gi];
    end
  endgenerate

endmodule

// File: rtl/apb_dma_regfile_mc.sv
// APB completer for NUM_CH DMA channel register pages: address decode,
// wait-state FSM, registered read mux and one-cycle write pulses.
module apb_dma_regfile_mc
  import apb_dma_regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_CH      = 4,
  parameter int PAGE_BITS   = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [31:0]               PWDATA,
  input  logic [3:0]                PSTRB,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CH*16*32-1:0]   cfg_regs,
  output logic [NUM_CH*16-1:0]      cfg_wr_pulse,
  input  logic [NUM_CH*32-1:0]      sts_set,
  input  logic [NUM_CH-1:0]         cmd_clr,
  input  logic [NUM_CH-1:0]         hw_upd_en,
  input  logic [NUM_CH*96-1:0]      hw_upd_data,
  input  logic [NUM_CH*32-1:0]      wrkregval
);

  localparam int CH_W   = ADDR_WIDTH - PAGE_BITS;
  localparam int WORD_W = PAGE_BITS - 2;
  localparam logic [CH_W:0]     CH_LIMIT = NUM_CH[CH_W:0];
  localparam logic [WORD_W-1:0] WORD_RO  = REG_WRKREGVAL[WORD_W-1:0];

  apb_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;
  logic [31:0]         prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [NUM_CH*16-1:0] pulse_q, pulse_d;

  logic [CH_W-1:0]     addr_ch;
  logic [WORD_W-1:0]   addr_word;
  logic                addr_err;
  logic [31:0]         rd_val;
  logic                commit;
  logic [NUM_REGS_RW*32-1:0] ch_flat [NUM_CH];

  assign addr_ch   = PADDR[ADDR_WIDTH-1:PAGE_BITS];
  assign addr_word = PADDR[PAGE_BITS-1:2];

  always_comb begin
    addr_err = ({1'b0, addr_ch} >= CH_LIMIT) || (addr_word > WORD_RO) ||
               (PADDR[1:0] != 2'b00) || (PWRITE && (addr_word == WORD_RO));
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(addr_ch) == c) begin
        if (addr_word == WORD_RO) begin
          rd_val = wrkregval[c*32 +: 32];
        end
        for (int r = 0; r < NUM_REGS_RW; r++) begin
          if (32'(addr_word) == r) begin
            rd_val = ch_flat[c][r*32 +: 32];
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    word_d    = word_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          ch_d     = addr_ch;
          word_d   = addr_word;
          wr_d     = PWRITE;
          err_d    = addr_err;
          wdata_d  = PWDATA;
          strb_d   = PSTRB;
          prdata_d = (!PWRITE && !addr_err) ? rd_val : 32'h0;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = addr_err;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // An all-zero strobe is a legal no-op: no commit and no pulse
        commit  = wr_q && !err_q && (strb_q != 4'h0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < NUM_REGS_RW; r++) begin
        pulse_d[c*16 + r] = commit && (32'(ch_q) == c) && (32'(word_q) == r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      word_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pulse_q   <= pulse_d;
    end
  end

  assign PRDATA       = prdata_q;
  assign PREADY       = pready_q;
  assign PSLVERR      = pslverr_q;
  assign cfg_wr_pulse = pulse_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      apb_dma_ch_regs u_ch_regs (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (commit && (32'(ch_q) == gi)),
        .wr_idx      (word_q[3:0]),
        .wr_data     (wdata_q),
        .wr_strb     (strb_q),
        .sts_set     (sts_set[gi*32 +: 32]),
        .cmd_clr     (cmd_clr[gi]),
        .hw_upd_en   (hw_upd_en[gi]),
        .hw_upd_data (hw_upd_data[gi*96 +: 96]),
        .regs        (ch_flat[gi])
      );
      assign cfg_regs[gi*NUM_REGS_RW*32 +: NUM_REGS_RW*32] = ch_flat[gi];
    end
  endgenerate

endmodule
